ar_id_gate: RTL and testbench
=============================

Name: ar_id_gate

Overview:
- AR-channel admission stage directly upstream of the reorder buffer's slave AR port.
- Blocks any AR whose ID is already in flight, because reorder storage is indexed by ID and duplicates would collide.
- Caps total outstanding reads and forwards admitted ARs through a one-entry register slice.
- Tracks completion by snooping R handshakes on the reorder buffer's slave R port.

Parameters:
- ID_WIDTH, 4: width of ARID/RID; NUM_IDS = 2**ID_WIDTH.
- MAX_OUTSTANDING, 16: admitted-but-not-returned limit; legal range 1..NUM_IDS (elaboration assertion).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- up_arid_i  in  ID_WIDTH  requester ARID
- up_arvalid_i  in  1  requester AR valid
- up_arready_o  out  1  AR accepted when high with up_arvalid_i
- dn_arid_o  out  ID_WIDTH  ARID to reorder buffer slave AR
- dn_arvalid_o  out  1  registered AR valid
- dn_arready_i  in  1  reorder buffer AR ready
- r_id_i  in  ID_WIDTH  snooped slave RID
- r_valid_i  in  1  snooped slave R valid
- r_ready_i  in  1  snooped slave R ready
- busy_o  out  NUM_IDS  per-ID in-flight bit vector
- outstanding_o  out  ID_WIDTH+1  in-flight count
- err_o  out  1  sticky protocol error

Behaviour:
- Reset: dn_arvalid_o=0, dn_arid_o=0, busy_o=0, outstanding_o=0, err_o=0. up_arready_o follows its equation and is 1 after reset.
- Reset mid-operation discards the held AR and clears all tracking. Responses arriving after reset for pre-reset IDs raise err_o.
- slot_free = !dn_arvalid_o || dn_arready_i.
- up_arready_o = slot_free && !busy_o[up_arid_i] && (outstanding_o < MAX_OUTSTANDING). Combinational on up_arid_i; no dependence on up_arvalid_i.
- accept = up_arvalid_i && up_arready_o. On accept: register loads up_arid_i, dn_arvalid_o=1 next cycle, busy_o[up_arid_i] sets.
- Latency is 1 cycle upstream to downstream. Throughput is 1 AR/cycle while dn_arready_i=1.
- dn_arvalid_o drops only after a downstream handshake with no accept in the same cycle. dn_arid_o is held stable while valid and unready (AXI rule).
- retire = r_valid_i && r_ready_i && busy_o[r_id_i]. It clears busy_o[r_id_i] and decrements the count.
- An R handshake with busy_o[r_id_i]=0 sets err_o and leaves state unchanged. err_o clears only on rst.
- Accept and retire in the same cycle leave the count unchanged. They cannot target the same ID, since accept requires busy=0 and retire requires busy=1.
- No same-cycle bypass: a retire does not raise up_arready_o until the next cycle, for both the full condition and the duplicate-ID condition.
- Count saturation is impossible by construction. An assertion checks outstanding_o <= MAX_OUTSTANDING.

Optional Feature:
- Macro AR_ID_GATE_STATS_EN.
- Defined: adds output stall_cnt_o [15:0], a saturating count (holds 16'hFFFF) of cycles with up_arvalid_i=1, slot_free=1 and up_arready_o=0 (ID/limit stalls only). Reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package ar_id_gate_pkg holds ID_WIDTH default, NUM_IDS, id_t (logic [ID_WIDTH-1:0]) and cnt_t (logic [ID_WIDTH:0]).
- One sub-module, ar_reg_slice: a one-entry valid/ready pipeline register with payload id_t, reused for the downstream register.
- Busy vector, counter and err logic stay in the top module.

Test Plan:
- Reset then AR id=3 with dn_arready_i=1: dn_arvalid_o=1 and dn_arid_o=3 one cycle later; busy_o=16'h0008; outstanding_o=1.
- Second AR id=3 before return: up_arready_o=0. R handshake id=3: busy bit clears, up_arready_o=1 the following cycle, id=3 forwarded.
- IDs 0..15 back-to-back with no returns: all accepted at 1/cycle, 17th request stalls with outstanding_o=16. One R return (id=7) re-enables only id 7 the next cycle.
- dn_arready_i=0 for 5 cycles with id=9 held: dn_arid_o stable at 9, up_arready_o=0; release completes the handshake, and a new id=2 is accepted in the same cycle.
- R handshake id=5 while busy_o[5]=0: err_o=1 sticky, busy_o and outstanding_o unchanged; rst=1 for one cycle restores all reset values.
- With AR_ID_GATE_STATS_EN defined: 4 cycles of a duplicate-ID stall give stall_cnt_o=4, and downstream-backpressure cycles are not counted.

Source files
------------

// File: rtl/ar_id_gate_pkg.sv
// Shared types for the AR ID admission gate: default ID width, ID count, ID and count types.
package ar_id_gate_pkg;
  localparam int ID_WIDTH_DEF = 4;
  localparam int NUM_IDS      = 2 ** ID_WIDTH_DEF;

  typedef logic [ID_WIDTH_DEF-1:0] id_t;
  typedef logic [ID_WIDTH_DEF:0]   cnt_t;
endpackage

// File: rtl/ar_reg_slice.sv
// One-entry valid/ready pipeline register: 1-cycle latency, full throughput,
// payload held stable while out_vld is high and out_rdy is low.
module ar_reg_slice
  import ar_id_gate_pkg::*;
#(
  parameter int W = $bits(id_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) out_dat <= in_dat;
    end
  end

endmodule

// File: rtl/ar_id_gate.sv
// AR admission gate: blocks in-flight IDs, caps outstanding reads, 1-cycle registered forward;
// backpressure via combinational up_arready_o. AR_ID_GATE_STATS_EN adds stall_cnt_o.
module ar_id_gate
  import ar_id_gate_pkg::*;
#(
  parameter int ID_WIDTH        = ID_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   up_arid_i,
  input  logic                  up_arvalid_i,
  output logic                  up_arready_o,
  output logic [ID_WIDTH-1:0]   dn_arid_o,
  output logic                  dn_arvalid_o,
  input  logic                  dn_arready_i,
  input  logic [ID_WIDTH-1:0]   r_id_i,
  input  logic                  r_valid_i,
  input  logic                  r_ready_i,
  output logic [2**ID_WIDTH-1:0] busy_o,
`ifdef AR_ID_GATE_STATS_EN
  output logic [15:0]           stall_cnt_o,
`endif
  output logic [ID_WIDTH:0]     outstanding_o,
  output logic                  err_o
);

  localparam int NUM_IDS = 2 ** ID_WIDTH;
  localparam logic [ID_WIDTH:0] MAX_CNT = MAX_OUTSTANDING[ID_WIDTH:0];

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > NUM_IDS) begin : g_bad_max
    $error("ar_id_gate: MAX_OUTSTANDING must lie in 1..2**ID_WIDTH");
  end

  logic               slot_free;
  logic               accept;
  logic               r_hs;
  logic               retire;
  logic [NUM_IDS-1:0] busy_q;
  logic [NUM_IDS-1:0] busy_nxt;
  logic [ID_WIDTH:0]  cnt_q;
  logic               err_q;

  // No same-cycle bypass: readiness looks only at registered busy/count state.
  assign up_arready_o = slot_free && !busy_q[up_arid_i] && (cnt_q < MAX_CNT);
  assign accept       = up_arvalid_i && up_arready_o;
  assign r_hs         = r_valid_i && r_ready_i;
  assign retire       = r_hs && busy_q[r_id_i];

  ar_reg_slice #(.W(ID_WIDTH)) u_slice (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (accept),
    .in_rdy  (slot_free),
    .in_dat  (up_arid_i),
    .out_vld (dn_arvalid_o),
    .out_rdy (dn_arready_i),
    .out_dat (dn_arid_o)
  );

  // Accept and retire never hit the same ID (busy must be 0 vs 1).
  always_comb begin
    busy_nxt = busy_q;
    if (retire) busy_nxt[r_id_i]    = 1'b0;
    if (accept) busy_nxt[up_arid_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (accept && !retire)      cnt_q <= cnt_q + 1'b1;
      else if (!accept && retire) cnt_q <= cnt_q - 1'b1;
      if (r_hs && !busy_q[r_id_i]) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (cnt_q <= MAX_CNT) else $error("ar_id_gate: outstanding count exceeds limit");
  end

`ifdef AR_ID_GATE_STATS_EN
  logic [15:0] stall_q;

  // Only ID/limit stalls count; downstream backpressure (slot busy) does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (up_arvalid_i && slot_free && !up_arready_o && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

  assign busy_o        = busy_q;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ar_id_gate.sv
// Scoreboard bench for ar_id_gate: reference model of the in-flight ID set drives expectations.
module tb_ar_id_gate;
  localparam int IDW  = 4;
  localparam int NIDS = 16;
  localparam int MAXO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [IDW-1:0]  up_arid_i;
  logic            up_arvalid_i;
  logic            up_arready_o;
  logic [IDW-1:0]  dn_arid_o;
  logic            dn_arvalid_o;
  logic            dn_arready_i;
  logic [IDW-1:0]  r_id_i;
  logic            r_valid_i;
  logic            r_ready_i;
  logic [NIDS-1:0] busy_o;
  logic [IDW:0]    outstanding_o;
  logic            err_o;
`ifdef AR_ID_GATE_STATS_EN
  logic [15:0]     stall_cnt_o;
`endif

  always #5 clk = ~clk;

  ar_id_gate #(.ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk           (clk),
    .rst           (rst),
    .up_arid_i     (up_arid_i),
    .up_arvalid_i  (up_arvalid_i),
    .up_arready_o  (up_arready_o),
    .dn_arid_o     (dn_arid_o),
    .dn_arvalid_o  (dn_arvalid_o),
    .dn_arready_i  (dn_arready_i),
    .r_id_i        (r_id_i),
    .r_valid_i     (r_valid_i),
    .r_ready_i     (r_ready_i),
    .busy_o        (busy_o),
`ifdef AR_ID_GATE_STATS_EN
    .stall_cnt_o   (stall_cnt_o),
`endif
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: set of in-flight IDs, whether an AR waits downstream, sticky error.
  bit infl[NIDS];
  int n_m     = 0;
  bit pend_m  = 0;
  bit err_m   = 0;
  int stall_m = 0;
  int exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] busy_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < NIDS; i++) v[i] = infl[i];
    return v;
  endfunction

  task automatic cycle(input bit r, input bit av, input int aid, input bit dr,
                       input bit rv, input bit rr, input int rid);
    bit slot, rdy, acc, rhs, ret;
    @(negedge clk);
    rst = r; up_arvalid_i = av; up_arid_i = aid[IDW-1:0]; dn_arready_i = dr;
    r_valid_i = rv; r_ready_i = rr; r_id_i = rid[IDW-1:0];
    #1;
    slot = !pend_m || dr;
    rdy  = slot && !infl[aid] && (n_m < MAXO);
    chk("up_arready", {31'b0, up_arready_o}, {31'b0, rdy});
    chk("busy", {16'b0, busy_o}, busy_vec());
    chk("outstanding", {27'b0, outstanding_o}, n_m);
    chk("err", {31'b0, err_o}, {31'b0, err_m});
    chk("dn_arvalid", {31'b0, dn_arvalid_o}, {31'b0, pend_m});
`ifdef AR_ID_GATE_STATS_EN
    chk("stall_cnt", {16'b0, stall_cnt_o}, stall_m);
`endif
    acc = av && rdy;
    rhs = rv && rr;
    ret = rhs && infl[rid];
    if (acc) exp_q.push_back(aid);
    @(posedge clk);
    if (r) begin
      foreach (infl[i]) infl[i] = 0;
      n_m = 0; pend_m = 0; err_m = 0; stall_m = 0;
      exp_q.delete();
    end else begin
      if (rhs && !infl[rid]) err_m = 1;
      if (ret) begin infl[rid] = 0; n_m--; end
      if (acc) begin infl[aid] = 1; n_m++; end
      if (slot) pend_m = acc;
      if (av && slot && !rdy && stall_m != 65535) stall_m++;
    end
  endtask

  // Monitor: every downstream handshake must carry the oldest admitted ID.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (dn_arvalid_o === 1'b1 && dn_arready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dn_handshake_unexpected actual_id=%0h expected=none", dn_arid_o);
        end else begin
          chk("dn_arid", {28'b0, dn_arid_o}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1; up_arvalid_i = 0; up_arid_i = 0; dn_arready_i = 0;
    r_valid_i = 0; r_ready_i = 0; r_id_i = 0;
    repeat (2) @(posedge clk);

    // Single AR id 3, then duplicate blocked until its R returns.
    cycle(0, 1, 3, 1, 0, 0, 0);
    cycle(0, 1, 3, 1, 0, 0, 0);
    cycle(0, 1, 3, 1, 0, 0, 0);
    cycle(0, 1, 3, 1, 1, 1, 3);
    cycle(0, 1, 3, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);

    // Fill all IDs, 17th stalls, a single return re-opens only that ID.
    cycle(1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < NIDS; i++) cycle(0, 1, i, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 0, 0);
    cycle(0, 1, 7, 1, 1, 1, 7);
    cycle(0, 1, 8, 1, 0, 0, 0);
    cycle(0, 1, 7, 1, 0, 0, 0);

    // Downstream backpressure holds id 9; release accepts id 2 in the same cycle.
    cycle(1, 0, 0, 1, 0, 0, 0);
    cycle(0, 1, 9, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 2, 0, 0, 0, 0);
    cycle(0, 1, 2, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);

    // Spurious R response, then reset recovery.
    cycle(0, 0, 0, 1, 1, 1, 5);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);

    // Duplicate-ID stall for 4 cycles with the slot free.
    cycle(0, 1, 6, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 6, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      bit rv, dr;
      int rid;
      rv  = ($urandom_range(0, 99) < 40);
      dr  = ($urandom_range(0, 99) < 75);
      rid = $urandom_range(0, NIDS - 1);
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 70),
            $urandom_range(0, NIDS - 1), dr, rv, ($urandom_range(0, 99) < 80), rid);
    end
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
